// File: rtl/drive_enve_memory_addr_gen.sv
// Envelope-memory address generator: answers the controller's set/increment strobes, issues reads, registers samples.
// Build option ENVE_ADDR_WRAP_EN: address wraps at the top of memory instead of saturating with a sticky overflow flag.
module drive_enve_memory_addr_gen #(
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 10,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_read_addr,
    input  logic                  set_enve_memory_addr,
    input  logic                  increment_enve_memory_addr,
    input  logic [ADDR_WIDTH-1:0] enve_start_addr,
    input  logic [LEN_WIDTH-1:0]  enve_length,
    output logic [ADDR_WIDTH-1:0] enve_memory_addr,
    output logic                  enve_memory_ren,
    input  logic [DATA_WIDTH-1:0] enve_memory_rdata,
    output logic [DATA_WIDTH-1:0] enve_sample,
    output logic                  enve_sample_valid,
    output logic                  is_read_env_fin,
    output logic                  enve_busy,
    output logic                  addr_overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state;
    logic [LEN_WIDTH-1:0]    remaining;
    logic [RD_LATENCY-1:0]   ren_dly;
    logic [RD_LATENCY-1:0]   ren_dly_next;
    logic                    dly_empty_next;
    logic                    advance;
    logic                    at_max;
    logic                    ovf_event;
    logic [ADDR_WIDTH-1:0]   addr_adv;

    // Delay line contents after this edge; drain ends as soon as it will be empty.
    always_comb begin
        ren_dly_next    = ren_dly << 1;
        ren_dly_next[0] = enve_memory_ren;
        dly_empty_next  = (ren_dly_next == '0);
    end

    assign advance = (state == READ) && !set_enve_memory_addr &&
                     increment_enve_memory_addr && (remaining != '0);
    assign at_max  = (enve_memory_addr == {ADDR_WIDTH{1'b1}});

`ifdef ENVE_ADDR_WRAP_EN
    assign addr_adv  = enve_memory_addr + ADDR_WIDTH'(1);
    assign ovf_event = 1'b0;
`else
    assign addr_adv  = at_max ? enve_memory_addr : enve_memory_addr + ADDR_WIDTH'(1);
    assign ovf_event = advance && at_max;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            remaining         <= '0;
            ren_dly           <= '0;
            enve_memory_addr  <= '0;
            enve_memory_ren   <= 1'b0;
            enve_sample       <= '0;
            enve_sample_valid <= 1'b0;
            is_read_env_fin   <= 1'b0;
            enve_busy         <= 1'b0;
            addr_overflow     <= 1'b0;
        end else begin
            ren_dly           <= ren_dly_next;
            enve_sample_valid <= ren_dly[RD_LATENCY-1];
            if (ren_dly[RD_LATENCY-1]) begin
                enve_sample <= enve_memory_rdata;
            end
`ifdef ENVE_ADDR_WRAP_EN
            addr_overflow <= 1'b0;
`else
            addr_overflow <= ovf_event | (addr_overflow & ~start_read_addr);
`endif

            if (set_enve_memory_addr) begin
                if (enve_length != '0) begin
                    enve_memory_addr <= enve_start_addr;
                    enve_memory_ren  <= 1'b1;
                    remaining        <= enve_length - LEN_WIDTH'(1);
                    is_read_env_fin  <= (enve_length == LEN_WIDTH'(1));
                    state            <= READ;
                    enve_busy        <= 1'b1;
                end else begin
                    enve_memory_ren  <= 1'b0;
                    remaining        <= '0;
                    is_read_env_fin  <= 1'b1;
                    state            <= IDLE;
                    enve_busy        <= 1'b0;
                end
            end else begin
                case (state)
                    READ: begin
                        if (increment_enve_memory_addr) begin
                            if (remaining != '0) begin
                                enve_memory_addr <= addr_adv;
                                enve_memory_ren  <= 1'b1;
                                remaining        <= remaining - LEN_WIDTH'(1);
                                is_read_env_fin  <= (remaining == LEN_WIDTH'(1));
                            end else begin
                                // Controller's trailing increment after the last address.
                                enve_memory_ren <= 1'b0;
                                is_read_env_fin <= 1'b0;
                                if (dly_empty_next) begin
                                    state     <= IDLE;
                                    enve_busy <= 1'b0;
                                end else begin
                                    state <= DRAIN;
                                end
                            end
                        end else begin
                            enve_memory_ren <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        enve_memory_ren <= 1'b0;
                        is_read_env_fin <= 1'b0;
                        if (dly_empty_next) begin
                            state     <= IDLE;
                            enve_busy <= 1'b0;
                        end
                    end
                    default: begin
                        enve_memory_ren <= 1'b0;
                        is_read_env_fin <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/drive_enve_memory_addr_gen.md
Name: drive_enve_memory_addr_gen

Overview:
- Responder side of the envelope-memory control handshake in the Horse Ridge I style drive circuit.
- Consumes the set/increment strobes from the drive control unit and holds the envelope memory address register.
- Issues read enables to the envelope memory and registers the returned samples.
- Reports end of envelope back to the controller on is_read_env_fin.

Parameters:
- ADDR_WIDTH, 10, envelope memory address width.
- LEN_WIDTH, 10, envelope length field width, in samples.
- DATA_WIDTH, 16, envelope sample width.
- RD_LATENCY, 1, envelope memory read latency in cycles, from ren to rdata valid; must be at least 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- start_read_addr  input  1  start strobe from controller; clears addr_overflow.
- set_enve_memory_addr  input  1  load strobe; captures enve_start_addr and enve_length.
- increment_enve_memory_addr  input  1  advance strobe.
- enve_start_addr  input  ADDR_WIDTH  first address of the envelope, sampled on set.
- enve_length  input  LEN_WIDTH  number of samples, sampled on set.
- enve_memory_addr  output  ADDR_WIDTH  address to envelope memory.
- enve_memory_ren  output  1  read enable to envelope memory.
- enve_memory_rdata  input  DATA_WIDTH  memory read data, valid RD_LATENCY cycles after ren.
- enve_sample  output  DATA_WIDTH  registered envelope sample.
- enve_sample_valid  output  1  enve_sample valid.
- is_read_env_fin  output  1  high in the cycle the final address is driven.
- enve_busy  output  1  state is not IDLE.
- addr_overflow  output  1  sticky; address ran past the top of memory.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, state is IDLE, remaining count is 0, the ren delay line is cleared.
- rst asserted mid-operation aborts immediately; in-flight samples are dropped.
- States are IDLE, READ and DRAIN.
- IDLE, set=1 with L=enve_length>=1:
  - next cycle: addr=enve_start_addr, ren=1, remaining=L-1, is_read_env_fin=(L==1); go to READ.
- IDLE, set=1 with L=0:
  - next cycle: is_read_env_fin=1 for one cycle, no ren; stay in IDLE.
- IDLE, no set: all strobes 0; increment is ignored.
- READ, increment=1 and remaining>0:
  - addr+1, ren=1, remaining-1.
  - is_read_env_fin=1 when remaining was 1; otherwise 0.
- READ, increment=1 and remaining==0 (the controller's single trailing increment):
  - ren=0, is_read_env_fin=0, addr held.
  - go to DRAIN, or to IDLE if the delay line is empty.
- READ, increment=0: stall. Addr held, ren=0, is_read_env_fin holds its value.
- set=1 in READ or DRAIN: restart with the new parameters as from IDLE (set wins over a coincident increment). Samples already in flight are still delivered.
- DRAIN: go to IDLE once no ren remains in the delay line.
- Handshake timing: set in cycle T gives addresses in cycles T+1 through T+L, one per cycle, with is_read_env_fin high in T+L. The controller's increment in T+L is absorbed.
- Sample path: ren is delayed RD_LATENCY cycles. When the delayed ren is 1, enve_sample<=rdata and enve_sample_valid<=1 in the next cycle. Total address-to-sample latency is RD_LATENCY+1.
- Address arithmetic is modulo 2^ADDR_WIDTH before the overflow rule below is applied.
- start_read_addr=1 clears addr_overflow in the same edge; a coincident overflow event sets it again.

Optional Feature:
- Macro: ENVE_ADDR_WRAP_EN.
- Defined: the address wraps from 2^ADDR_WIDTH-1 to 0. addr_overflow is tied to 0.
- Undefined: an advance from 2^ADDR_WIDTH-1 with remaining>0 saturates.
  - addr is held at the maximum and the last address is re-read.
  - addr_overflow is set sticky.
  - remaining still decrements, so is_read_env_fin timing is unchanged.

Test Plan:
- Nominal read: set plus start with start=0x010, L=4, increment held per controller, RD_LATENCY=1 -> addr 0x010..0x013 in cycles T+1..T+4, ren=1 in those cycles, fin=1 only in T+4, samples valid in T+3..T+6, IDLE in T+6.
- Zero and one length: L=0 -> fin pulse in T+1 with no ren and busy=0. L=1 -> addr=start, ren=1 and fin=1 all in T+1.
- Stall: L=3 with increment dropped for 2 cycles after the first address -> addr held and ren=0 during the stall, 3 total reads, fin on the third address.
- Restart and reset: set with L=8, then a new set at the 3rd address with start=0x100, L=2 -> addr 0x100, 0x101 with fin on 0x101, and the earlier in-flight samples still delivered. rst at the 2nd address -> all outputs 0 in the next cycle.
- Overflow: start=0x3FE, L=4.
  - Without the macro -> addr 0x3FE, 0x3FF, 0x3FF, 0x3FF, addr_overflow=1, fin on the 4th address.
  - With ENVE_ADDR_WRAP_EN -> addr 0x3FE, 0x3FF, 0x000, 0x001, addr_overflow=0.
  - A following start_read_addr clears addr_overflow.
- Latency sweep: RD_LATENCY=3, L=5 -> enve_sample_valid in T+5..T+9, DRAIN held until the delay line empties.
